// File: rtl/xor_parity_serializer_pkg.sv
// rtl/xor_parity_serializer_pkg.sv - shared state encoding and parity-sense constants
package xor_parity_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/xor_parity_serializer_parity_acc.sv
// rtl/xor_parity_serializer_parity_acc.sv - 1-bit XOR accumulator, also used by the downstream checker
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic init,
  input  logic en,
  input  logic d,
  output logic q
);

  // clr wins over en so a word start always seeds from init
  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (clr) q <= init;
    else if (en)  q <= q ^ d;
  end

endmodule

// File: rtl/xor_parity_serializer.sv
// rtl/xor_parity_serializer.sv - LSB-first word serialiser with appended parity bit
module xor_parity_serializer
  import xor_parity_serializer_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic ODD   = PARITY_EVEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_is_par,
  output logic             parity,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             acc_q;
  logic             accept;
  logic             shifting;
  logic             finishing;
  logic             illegal;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = accept ? S_SHIFT : S_IDLE;
      S_SHIFT: state_next = (cnt == CNT_LAST) ? S_PAR : S_SHIFT;
      S_PAR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    shifting  = 1'b0;
    finishing = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE:  accept    = in_valid & in_ready;
      S_SHIFT: shifting  = 1'b1;
      S_PAR:   finishing = 1'b1;
      default: illegal   = 1'b1;
    endcase
  end

  // An unreachable encoding is treated exactly like reset for one edge
  always_ff @(posedge clk) begin
    if (rst || illegal) begin
      sr         <= '0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      bit_is_par <= 1'b0;
      parity     <= 1'b0;
      done       <= 1'b0;
    end else if (accept) begin
      sr         <= in_data;
      cnt        <= '0;
      in_ready   <= 1'b0;
      bit_valid  <= 1'b0;
      bit_is_par <= 1'b0;
      done       <= 1'b0;
    end else if (shifting) begin
      bit_out    <= sr[0];
      bit_valid  <= 1'b1;
      sr         <= sr >> 1;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (finishing) begin
      bit_out    <= acc_q;
      bit_is_par <= 1'b1;
      done       <= 1'b1;
      parity     <= acc_q;
      in_ready   <= 1'b1;
    end else begin
      bit_valid  <= 1'b0;
      bit_is_par <= 1'b0;
      done       <= 1'b0;
    end
  end

  parity_acc u_acc (
    .clk  (clk),
    .rst  (rst | illegal),
    .clr  (accept),
    .init (ODD),
    .en   (shifting),
    .d    (sr[0]),
    .q    (acc_q)
  );

endmodule

// File: tb/tb_xor_parity_serializer.sv
// tb/tb_xor_parity_serializer.sv - directed and random checks of even/odd serialiser instances
module tb_xor_parity_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready_e, bit_out_e, bit_valid_e, bit_is_par_e, parity_e, done_e;
  logic       in_ready_o, bit_out_o, bit_valid_o, bit_is_par_o, parity_o, done_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt_e = 0;
  int done_cnt_o = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done_e) done_cnt_e++;
    if (done_o) done_cnt_o++;
  end

  xor_parity_serializer #(.WIDTH(8), .ODD(1'b0)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e), .in_data(in_data),
    .bit_out(bit_out_e), .bit_valid(bit_valid_e), .bit_is_par(bit_is_par_e),
    .parity(parity_e), .done(done_e)
  );

  xor_parity_serializer #(.WIDTH(8), .ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o), .in_data(in_data),
    .bit_out(bit_out_o), .bit_valid(bit_valid_o), .bit_is_par(bit_is_par_o),
    .parity(parity_o), .done(done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bits leave LSB first, parity = XOR of all data bits, inverted for odd sense
  task automatic send_word(input logic [7:0] data, input bit hold, output int acc_cyc);
    int   guard;
    logic pe;
    logic po;
    pe = ^data;
    po = ~pe;
    in_valid = 1'b1;
    in_data  = data;
    guard = 0;
    while (!(in_ready_e && in_ready_o) && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_timeout", 32'(guard < 50), 32'd1);
    tick();
    acc_cyc  = cyc;
    in_valid = hold;
    in_data  = 8'($urandom);
    check("e0_ready", {in_ready_e, in_ready_o}, 2'b00);
    check("e0_quiet", {bit_valid_e, bit_valid_o, done_e, done_o}, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick();
      in_data = 8'($urandom);
      check("data_bit", {bit_out_e, bit_out_o, bit_valid_e, bit_valid_o, bit_is_par_e, done_e},
            {data[k], data[k], 1'b1, 1'b1, 1'b0, 1'b0});
    end
    tick();
    check("par_even", {bit_out_e, bit_is_par_e, done_e, parity_e, in_ready_e},
          {pe, 1'b1, 1'b1, pe, 1'b1});
    check("par_odd", {bit_out_o, bit_is_par_o, done_o, parity_o, in_ready_o},
          {po, 1'b1, 1'b1, po, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, t1, gap, accepts;
    logic [7:0] w;

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    tick();
    check("rst_outputs", {in_ready_e, bit_valid_e, done_e, parity_e, bit_out_e, bit_is_par_e},
          6'b100000);
    check("rst_outputs_o", {in_ready_o, bit_valid_o, done_o, parity_o}, 4'b1000);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("no_accept_in_rst", {in_ready_e, bit_valid_e}, 2'b10);

    send_word(8'hA5, 1'b0, t0);
    check("a5_parity", parity_e, 1'b0);
    in_valid = 1'b0;
    tick();

    send_word(8'h07, 1'b0, t0);
    check("h07_par_even", parity_e, 1'b1);
    check("h07_par_odd", parity_o, 1'b0);
    in_valid = 1'b0;
    send_word(8'h00, 1'b0, t0);
    check("h00_par_even", parity_e, 1'b0);

    send_word(8'hFF, 1'b1, t0);
    send_word(8'h01, 1'b0, t1);
    check("b2b_spacing", 32'(t1 - t0), 32'd10);
    check("b2b_parity", parity_e, 1'b1);
    in_valid = 1'b0;
    tick();

    // Abort mid-word: reset lands one cycle after bit 3 is presented
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("c3_bit3", {bit_out_e, bit_valid_e}, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_reset", {in_ready_e, bit_out_e, bit_valid_e, bit_is_par_e, parity_e, done_e},
          6'b100000);
    check("abort_reset_o", {in_ready_o, bit_valid_o, parity_o, done_o}, 4'b1000);
    t0 = done_cnt_e;
    repeat (12) tick();
    check("abort_no_done", 32'(done_cnt_e - t0), 32'd0);
    send_word(8'h01, 1'b0, t0);
    check("after_abort_par", parity_e, 1'b1);

    accepts    = 0;
    in_valid   = 1'b0;
    tick();
    done_cnt_e = 0;
    done_cnt_o = 0;
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("idle_quiet", {bit_valid_e, bit_valid_o, done_e, done_o}, 4'b0000);
      end
      w = 8'($urandom);
      send_word(w, (i % 3) == 0, t0);
      accepts++;
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("done_count_e", 32'(done_cnt_e), 32'(accepts));
    check("done_count_o", 32'(done_cnt_o), 32'(accepts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
